// File: rtl/debounce_fsm.sv
// Debouncer: a new input level must hold for STABLE_CYCLES EN-qualified samples before DEBOUNCED follows it.
// Define DEBOUNCE_SYNC_EN to put a 2-flop synchronizer (clocked every edge) in front of the FSM.
module debounce_fsm #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned COUNT_WIDTH   = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic NOISY_IN,
  output logic DEBOUNCED,
  output logic RISE_PULSE,
  output logic FALL_PULSE,
  output logic BUSY
);

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] LAST_CNT = COUNT_WIDTH'(STABLE_CYCLES - 1);

  state_t                 r_state;
  logic [COUNT_WIDTH-1:0] r_cnt;
  logic                   r_debounced;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_busy;
  logic                   w_in;

`ifdef DEBOUNCE_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge CLK) begin
    if (RST) r_sync <= '0;
    else     r_sync <= {r_sync[0], NOISY_IN};
  end

  assign w_in = r_sync[1];
`else
  assign w_in = NOISY_IN;
`endif

  // Pulses clear on every edge; state, count and level only move on EN edges.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE_LOW;
      r_cnt       <= '0;
      r_debounced <= 1'b0;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (EN) begin
        case (r_state)
          IDLE_LOW: begin
            if (w_in) begin
              r_state <= WAIT_HIGH;
              r_cnt   <= COUNT_WIDTH'(1);
              r_busy  <= 1'b1;
            end else begin
              r_cnt   <= '0;
            end
          end
          WAIT_HIGH: begin
            if (!w_in) begin
              r_state <= IDLE_LOW;
              r_cnt   <= '0;
              r_busy  <= 1'b0;
            end else if (r_cnt == LAST_CNT) begin
              r_state     <= IDLE_HIGH;
              r_cnt       <= '0;
              r_debounced <= 1'b1;
              r_rise      <= 1'b1;
              r_busy      <= 1'b0;
            end else begin
              r_cnt <= r_cnt + COUNT_WIDTH'(1);
            end
          end
          IDLE_HIGH: begin
            if (!w_in) begin
              r_state <= WAIT_LOW;
              r_cnt   <= COUNT_WIDTH'(1);
              r_busy  <= 1'b1;
            end else begin
              r_cnt   <= '0;
            end
          end
          WAIT_LOW: begin
            if (w_in) begin
              r_state <= IDLE_HIGH;
              r_cnt   <= '0;
              r_busy  <= 1'b0;
            end else if (r_cnt == LAST_CNT) begin
              r_state     <= IDLE_LOW;
              r_cnt       <= '0;
              r_debounced <= 1'b0;
              r_fall      <= 1'b1;
              r_busy      <= 1'b0;
            end else begin
              r_cnt <= r_cnt + COUNT_WIDTH'(1);
            end
          end
          default: begin
            r_state     <= IDLE_LOW;
            r_cnt       <= '0;
            r_debounced <= 1'b0;
            r_busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign DEBOUNCED  = r_debounced;
  assign RISE_PULSE = r_rise;
  assign FALL_PULSE = r_fall;
  assign BUSY       = r_busy;

endmodule

// File: tb/tb_debounce_fsm.sv
// Bench for debounce_fsm: run-length model of the debounce rule checked every cycle, plus literal spot checks.
module tb_debounce_fsm;

  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic noisy = 1'b0;
  logic deb, rise, fall, busy;

  int errors = 0;
  int checks = 0;

  debounce_fsm #(.STABLE_CYCLES(N), .COUNT_WIDTH(16)) u_dut (
    .CLK       (clk),
    .RST       (rst),
    .EN        (en),
    .NOISY_IN  (noisy),
    .DEBOUNCED (deb),
    .RISE_PULSE(rise),
    .FALL_PULSE(fall),
    .BUSY      (busy)
  );

  always #5 clk = ~clk;

  // Model: count consecutive EN samples that disagree with the committed level.
  bit m_deb = 0, m_rise = 0, m_fall = 0, m_busy = 0, m_valid = 0;
  int m_run = 0;
  bit m_p0 = 0, m_p1 = 0;

  always @(posedge clk) begin
    bit s;
`ifdef DEBOUNCE_SYNC_EN
    s = m_p1;
    m_p1 = m_p0;
    m_p0 = noisy;
`else
    s = noisy;
`endif
    m_rise = 0;
    m_fall = 0;
    if (rst) begin
      m_deb = 0; m_busy = 0; m_run = 0; m_p0 = 0; m_p1 = 0;
      m_valid = 1;
    end else if (en) begin
      if (s == m_deb) m_run = 0;
      else            m_run = m_run + 1;
      if (m_run == N) begin
        m_deb  = ~m_deb;
        m_rise = m_deb;
        m_fall = ~m_deb;
        m_run  = 0;
      end
      m_busy = (m_run > 0);
    end
  end

  task automatic cmp(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      cmp("model_debounced", deb, m_deb);
      cmp("model_rise", rise, m_rise);
      cmp("model_fall", fall, m_fall);
      cmp("model_busy", busy, m_busy);
      cmp("pulse_exclusive", rise & fall, 1'b0);
    end
  end

  task automatic cyc(input logic r, input logic e, input logic n);
    rst = r; en = e; noisy = n;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] pat;

  initial begin
    cyc(1, 0, 0);
    cyc(1, 1, 1);
`ifndef DEBOUNCE_SYNC_EN
    cmp("reset_deb", deb, 1'b0);
    cmp("reset_busy", busy, 1'b0);
    cmp("reset_rise", rise, 1'b0);

    // Clean rise: busy for 3 samples, commit on the 4th.
    for (int unsigned i = 1; i < N; i++) begin
      cyc(0, 1, 1);
      cmp("rise_wait_busy", busy, 1'b1);
      cmp("rise_wait_deb", deb, 1'b0);
    end
    cyc(0, 1, 1);
    cmp("rise_commit_deb", deb, 1'b1);
    cmp("rise_commit_pulse", rise, 1'b1);
    cmp("rise_commit_busy", busy, 1'b0);
    cyc(0, 0, 1);
    cmp("rise_pulse_drops_en0", rise, 1'b0);

    // Glitch low shorter than N while high.
    cyc(0, 1, 0); cyc(0, 1, 0); cyc(0, 1, 1);
    cmp("glitch_hi_deb", deb, 1'b1);
    cmp("glitch_hi_busy", busy, 1'b0);

    // Clean fall.
    for (int unsigned i = 1; i < N; i++) cyc(0, 1, 0);
    cmp("fall_wait_deb", deb, 1'b1);
    cyc(0, 1, 0);
    cmp("fall_commit_deb", deb, 1'b0);
    cmp("fall_commit_pulse", fall, 1'b1);
    cmp("fall_no_rise", rise, 1'b0);

    // Three high samples then low: nothing commits.
    cyc(0, 1, 1); cyc(0, 1, 1); cyc(0, 1, 1);
    cmp("short_hi_busy", busy, 1'b1);
    cyc(0, 1, 0);
    cmp("short_hi_deb", deb, 1'b0);
    cmp("short_hi_busy_clr", busy, 1'b0);

    // EN alternating: commit on 7th edge (4th EN=1 edge).
    for (int unsigned i = 1; i <= 6; i++) cyc(0, (i % 2) == 1, 1);
    cmp("en_toggle_pre_deb", deb, 1'b0);
    cmp("en_toggle_pre_busy", busy, 1'b1);
    cyc(0, 1, 1);
    cmp("en_toggle_deb", deb, 1'b1);
    cmp("en_toggle_rise", rise, 1'b1);

    // Back low, then reset mid-WAIT_HIGH at count 2.
    for (int unsigned i = 0; i < N; i++) cyc(0, 1, 0);
    cmp("back_low", deb, 1'b0);
    cyc(0, 1, 1); cyc(0, 1, 1);
    cyc(1, 1, 1);
    cmp("midwait_rst_busy", busy, 1'b0);
    cmp("midwait_rst_deb", deb, 1'b0);
    cmp("midwait_rst_rise", rise, 1'b0);
    for (int unsigned i = 1; i < N; i++) cyc(0, 1, 1);
    cmp("post_rst_fresh_count", deb, 1'b0);
    cyc(0, 1, 1);
    cmp("post_rst_commit", deb, 1'b1);
    cmp("post_rst_rise", rise, 1'b1);
`endif

    // Directed noisy pattern with EN gaps; checked by the model each cycle.
    pat = 32'b1011_0111_1101_0000_1111_0010_1110_1111;
    for (int i = 31; i >= 0; i--) cyc(0, (i % 5) != 0, pat[i]);
    pat = 32'b0000_0101_1111_1111_0000_1000_0111_1000;
    for (int i = 31; i >= 0; i--) cyc(0, 1'b1, pat[i]);
    for (int i = 0; i < 12; i++) cyc(0, 1'b0, 1'b0);
    cyc(1, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 1'b1, 1'b1);
    cyc(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
